// File: rtl/sub.sv
// ---------------------------------------------------------------------------
// sub -- registered unsigned subtractor with optional clamp-to-zero on borrow.
//
// One operation per cycle, fixed 1-cycle latency, no backpressure. All outputs
// come straight from flops, so there is no combinational path from a, b or
// in_valid to any output.
//
// Parameters
//   DATAWIDTH  operand/result width in bits (1..64)
//   SATURATE   0 = modular wrap-around, 1 = clamp diff to 0 when a < b
//
// Ports
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset
//   a, b       unsigned minuend / subtrahend (DATAWIDTH bits)
//   in_valid   qualifies a/b for capture on this edge
//   diff       registered difference (held while in_valid is low)
//   borrow     registered borrow, 1 when a < b (held while in_valid is low)
//   zero       registered flag, 1 when the registered diff is 0
//   out_valid  1 for exactly the cycle after a captured in_valid
// ---------------------------------------------------------------------------
module sub #(
   parameter int unsigned DATAWIDTH = 2,
   parameter int unsigned SATURATE  = 0
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic                 in_valid,
   output logic [DATAWIDTH-1:0] diff,
   output logic                 borrow,
   output logic                 zero,
   output logic                 out_valid
);

   localparam int unsigned W = DATAWIDTH;

   logic [W:0]   full_c;
   logic         borrow_c;
   logic [W-1:0] diff_c;
   logic         zero_c;

   // Widen by one bit so the top bit of the difference is the borrow.
   always_comb begin
      full_c   = {1'b0, a} - {1'b0, b};
      borrow_c = full_c[W];
      diff_c   = full_c[W-1:0];
      if ((SATURATE != 0) && borrow_c) begin
         diff_c = '0;
      end
      // Zero reflects the final (post-clamp) result.
      zero_c   = (diff_c == '0);
   end

   // Result registers: reset wins over capture; idle cycles hold the result.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         diff      <= '0;
         borrow    <= 1'b0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         diff      <= diff_c;
         borrow    <= borrow_c;
         zero      <= zero_c;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sub.sv
// ---------------------------------------------------------------------------
// tb_sub -- directed-vector bench for sub. Four instances share clock, reset
// and in_valid: 2-bit wrap, 8-bit wrap, 8-bit saturate, 64-bit wrap.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sub;

   logic        clk;
   logic        rst;
   logic        in_valid;

   logic [1:0]  a2, b2, diff2;
   logic        borrow2, zero2, ov2;
   logic [7:0]  a8, b8, diff8w, diff8s;
   logic        borrow8w, zero8w, ov8w;
   logic        borrow8s, zero8s, ov8s;
   logic [63:0] a64, b64, diff64;
   logic        borrow64, zero64, ov64;

   int vectors;
   int miscompares;

   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   sub #(.DATAWIDTH(2), .SATURATE(0)) dut2 (
      .Clk(clk), .Rst(rst), .a(a2), .b(b2), .in_valid(in_valid),
      .diff(diff2), .borrow(borrow2), .zero(zero2), .out_valid(ov2));

   sub #(.DATAWIDTH(8), .SATURATE(0)) dut8w (
      .Clk(clk), .Rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
      .diff(diff8w), .borrow(borrow8w), .zero(zero8w), .out_valid(ov8w));

   sub #(.DATAWIDTH(8), .SATURATE(1)) dut8s (
      .Clk(clk), .Rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
      .diff(diff8s), .borrow(borrow8s), .zero(zero8s), .out_valid(ov8s));

   sub #(.DATAWIDTH(64), .SATURATE(0)) dut64 (
      .Clk(clk), .Rst(rst), .a(a64), .b(b64), .in_valid(in_valid),
      .diff(diff64), .borrow(borrow64), .zero(zero64), .out_valid(ov64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive operands; wider environment values are cut to port width here.
   task automatic drive(input logic [31:0] va2, input logic [31:0] vb2,
                        input logic [31:0] va8, input logic [31:0] vb8,
                        input logic [63:0] va64, input logic [63:0] vb64);
      a2  = 2'(va2);
      b2  = 2'(vb2);
      a8  = 8'(va8);
      b8  = 8'(vb8);
      a64 = va64;
      b64 = vb64;
   endtask

   task automatic chk2(input string tag, input logic [1:0] d, input logic bo,
                       input logic z, input logic ov);
      chk({tag, ".d2.diff"},   64'(diff2),   64'(d));
      chk({tag, ".d2.borrow"}, 64'(borrow2), 64'(bo));
      chk({tag, ".d2.zero"},   64'(zero2),   64'(z));
      chk({tag, ".d2.ov"},     64'(ov2),     64'(ov));
   endtask

   task automatic chk8(input string tag, input logic [7:0] dw, input logic bw,
                       input logic [7:0] ds, input logic bs, input logic ov);
      chk({tag, ".d8w.diff"},   64'(diff8w),   64'(dw));
      chk({tag, ".d8w.borrow"}, 64'(borrow8w), 64'(bw));
      chk({tag, ".d8w.zero"},   64'(zero8w),   64'(dw == 8'd0));
      chk({tag, ".d8w.ov"},     64'(ov8w),     64'(ov));
      chk({tag, ".d8s.diff"},   64'(diff8s),   64'(ds));
      chk({tag, ".d8s.borrow"}, 64'(borrow8s), 64'(bs));
      chk({tag, ".d8s.zero"},   64'(zero8s),   64'(ds == 8'd0));
      chk({tag, ".d8s.ov"},     64'(ov8s),     64'(ov));
   endtask

   task automatic chk64(input string tag, input logic [63:0] d, input logic bo,
                        input logic ov);
      chk({tag, ".d64.diff"},   diff64,          d);
      chk({tag, ".d64.borrow"}, 64'(borrow64),   64'(bo));
      chk({tag, ".d64.zero"},   64'(zero64),     64'(d == 64'd0));
      chk({tag, ".d64.ov"},     64'(ov64),       64'(ov));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      drive(0, 0, 0, 0, 64'd0, 64'd0);

      // Reset held on the same edge as a valid operation: it must be dropped.
      @(negedge clk);
      in_valid = 1'b1;
      drive(1, 0, 9, 3, 64'd9, 64'd3);
      @(negedge clk);
      chk2 ("rst", 2'd0, 1'b0, 1'b1, 1'b0);
      chk8 ("rst", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      chk64("rst", 64'd0, 1'b0, 1'b0);

      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk2 ("post_rst", 2'd0, 1'b0, 1'b1, 1'b0);
      chk8 ("post_rst", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      chk64("post_rst", 64'd0, 1'b0, 1'b0);

      // Three back-to-back operations.
      in_valid = 1'b1;
      drive(10, 0, 15, 20, 64'd5, 64'd3);
      @(negedge clk);
      chk2 ("v1", 2'd2, 1'b0, 1'b0, 1'b1);
      chk8 ("v1", 8'd251, 1'b1, 8'd0, 1'b1, 1'b1);
      chk64("v1", 64'd2, 1'b0, 1'b1);

      drive(15, 5, 77, 77, 64'd0, 64'd1);
      @(negedge clk);
      chk2 ("v2", 2'd2, 1'b0, 1'b0, 1'b1);
      chk8 ("v2", 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      chk64("v2", ALL1, 1'b1, 1'b1);

      drive(15, 20, 0, 255, ALL1, ALL1);
      @(negedge clk);
      chk2 ("v3", 2'd3, 1'b0, 1'b0, 1'b1);
      chk8 ("v3", 8'd1, 1'b1, 8'd0, 1'b1, 1'b1);
      chk64("v3", 64'd0, 1'b0, 1'b1);

      // Idle: results hold, out_valid drops, new operands ignored.
      in_valid = 1'b0;
      drive(0, 3, 1, 2, 64'd1, 64'd7);
      @(negedge clk);
      chk2 ("idle", 2'd3, 1'b0, 1'b0, 1'b0);
      chk8 ("idle", 8'd1, 1'b1, 8'd0, 1'b1, 1'b0);
      chk64("idle", 64'd0, 1'b0, 1'b0);

      // Borrow at 2 bits, no-borrow at 8 bits, maximum at 64 bits.
      in_valid = 1'b1;
      drive(1, 2, 200, 100, ALL1, 64'd0);
      @(negedge clk);
      chk2 ("v4", 2'd3, 1'b1, 1'b0, 1'b1);
      chk8 ("v4", 8'd100, 1'b0, 8'd100, 1'b0, 1'b1);
      chk64("v4", ALL1, 1'b0, 1'b1);

      // Mid-stream reset with in_valid still high.
      rst = 1'b1;
      drive(3, 0, 9, 3, 64'd9, 64'd3);
      @(negedge clk);
      chk2 ("rst2", 2'd0, 1'b0, 1'b1, 1'b0);
      chk8 ("rst2", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      chk64("rst2", 64'd0, 1'b0, 1'b0);

      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk2 ("rst2_after", 2'd0, 1'b0, 1'b1, 1'b0);
      chk8 ("rst2_after", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
